// File: rtl/key_arb_pkg.sv
// key_arb_pkg: note scan codes, owner/state types and the note-code filter for the key source arbiter
package key_arb_pkg;
  localparam logic [7:0] NOTE_Z = 8'h1A;
  localparam logic [7:0] NOTE_X = 8'h22;
  localparam logic [7:0] NOTE_C = 8'h21;
  localparam logic [7:0] NOTE_V = 8'h2A;
  localparam logic [7:0] NOTE_B = 8'h32;
  localparam logic [7:0] NOTE_N = 8'h31;
  localparam logic [7:0] NOTE_M = 8'h3A;
  localparam int HOLD_MAX_DEFAULT = 50_000_000;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_MAN = 2'b01, OWN_AUTO = 2'b10} owner_t;
  typedef enum logic [1:0] {ST_IDLE, ST_MAN, ST_AUTO} state_t;
  function automatic logic is_note_code(input logic [7:0] c);
    return c inside {NOTE_Z, NOTE_X, NOTE_C, NOTE_V, NOTE_B, NOTE_N, NOTE_M};
  endfunction
endpackage

// File: rtl/key_event_slot.sv
// key_event_slot: 1-deep pending press register; an incoming press is visible in the same cycle
module key_event_slot
  import key_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       valid,
  input  logic       clr,
  output logic       pend,
  output logic [7:0] pcode,
  output logic       ovf
);
  logic       full;
  logic [7:0] held;
  logic       press;
  assign press = valid && is_note_code(code);
  assign pend  = full || press;
  assign pcode = press ? code : held;
  assign ovf   = full && press;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      held <= '0;
    end else begin
      full <= pend && !clr;
      held <= pcode;
    end
  end
endmodule

// File: rtl/key_source_arbiter.sv
// key_source_arbiter: shares the note channel between manual and auto-play sources, manual first.
// Optional AUTO_LOCKOUT_EN mutes auto presses for LOCKOUT_CYCLES after each manual grant.
module key_source_arbiter
  import key_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
`ifdef AUTO_LOCKOUT_EN
  parameter int LOCKOUT_CYCLES = 100_000_000,
`endif
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       man_code,
  input  logic             man_valid,
  input  logic             man_release,
  input  logic [7:0]       auto_code,
  input  logic             auto_valid,
  input  logic             auto_release,
  output logic [7:0]       note_code,
  output logic             note_on,
  output logic             note_start,
  output logic [1:0]       owner,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int HW = $clog2(HOLD_MAX + 1);
  state_t        state, state_d;
  logic [HW-1:0] hold, hold_d;
  logic [7:0]    code_d, man_pcode, auto_pcode;
  logic          start_d, man_clr, auto_clr, drop, auto_in, lock_drop;
  logic          man_pend, auto_pend, auto_ovf, man_ovf_unused;
  logic          timeout, man_rel, auto_rel;
`ifdef AUTO_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LW-1:0] lock;
  assign auto_in   = auto_valid && lock == '0;
  assign lock_drop = auto_valid && lock != '0 && is_note_code(auto_code);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lock <= '0;
    else if (state_d == ST_MAN && start_d) lock <= LW'(LOCKOUT_CYCLES);
    else if (lock != '0) lock <= lock - LW'(1);
  end
`else
  assign auto_in   = auto_valid;
  assign lock_drop = 1'b0;
`endif
  key_event_slot u_man_slot (
    .clk(clk), .rst(rst), .code(man_code), .valid(man_valid), .clr(man_clr),
    .pend(man_pend), .pcode(man_pcode), .ovf(man_ovf_unused)
  );
  key_event_slot u_auto_slot (
    .clk(clk), .rst(rst), .code(auto_code), .valid(auto_in), .clr(auto_clr),
    .pend(auto_pend), .pcode(auto_pcode), .ovf(auto_ovf)
  );
  assign timeout  = hold == HW'(HOLD_MAX - 1);
  assign man_rel  = man_release && man_code == note_code;
  assign auto_rel = auto_release && auto_code == note_code;
  assign note_on  = state != ST_IDLE;
  assign owner    = state == ST_MAN ? OWN_MAN : state == ST_AUTO ? OWN_AUTO : OWN_NONE;
  // A press on the same cycle as a matching release behaves as release-then-press, i.e. a retrigger.
  always_comb begin
    state_d  = state;
    code_d   = note_code;
    start_d  = 1'b0;
    hold_d   = hold + HW'(1);
    man_clr  = 1'b0;
    auto_clr = 1'b0;
    drop     = auto_ovf || lock_drop;
    case (state)
      ST_MAN: begin
        if (timeout) begin
          state_d = ST_IDLE;
          code_d  = '0;
          man_clr = 1'b1;
        end else if (man_pend) begin
          code_d  = man_pcode;
          start_d = 1'b1;
          hold_d  = '0;
          man_clr = 1'b1;
        end else if (man_rel) begin
          state_d = ST_IDLE;
          code_d  = '0;
        end
      end
      ST_AUTO: begin
        if (timeout) begin
          state_d  = ST_IDLE;
          code_d   = '0;
          auto_clr = 1'b1;
          drop     = drop || auto_pend;
        end else if (man_pend) begin
          state_d  = ST_MAN;
          code_d   = man_pcode;
          start_d  = 1'b1;
          hold_d   = '0;
          man_clr  = 1'b1;
          auto_clr = 1'b1;
          drop     = drop || auto_pend;
        end else if (auto_pend) begin
          code_d   = auto_pcode;
          start_d  = 1'b1;
          hold_d   = '0;
          auto_clr = 1'b1;
        end else if (auto_rel) begin
          state_d = ST_IDLE;
          code_d  = '0;
        end
      end
      default: begin
        hold_d = '0;
        if (man_pend) begin
          state_d  = ST_MAN;
          code_d   = man_pcode;
          start_d  = 1'b1;
          man_clr  = 1'b1;
          auto_clr = 1'b1;
          drop     = drop || auto_pend;
        end else if (auto_pend) begin
          state_d  = ST_AUTO;
          code_d   = auto_pcode;
          start_d  = 1'b1;
          auto_clr = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      note_code  <= '0;
      note_start <= 1'b0;
      hold       <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_d;
      note_code  <= code_d;
      note_start <= start_d;
      hold       <= hold_d;
      drop_cnt   <= (drop && !(&drop_cnt)) ? drop_cnt + CNT_W'(1) : drop_cnt;
    end
  end
endmodule

// File: tb/tb_key_source_arbiter.sv
// tb_key_source_arbiter: directed checks of grant, retrigger, pre-emption, hold timeout and reset.
// Build with AUTO_LOCKOUT_EN defined to add the auto lockout scenario.
module tb_key_source_arbiter;
  logic       clk = 1'b0, rst = 1'b0;
  logic [7:0] man_code = '0, auto_code = '0;
  logic       man_valid = 1'b0, man_release = 1'b0, auto_valid = 1'b0, auto_release = 1'b0;
  logic [7:0] note_code, h_note_code, drop_cnt, h_drop_cnt;
  logic       note_on, note_start, h_note_on, h_note_start;
  logic [1:0] owner, h_owner;
  logic [11:0] exp;
  int vec = 0, errs = 0;
`ifdef AUTO_LOCKOUT_EN
  localparam int GAP = 40;
`else
  localparam int GAP = 2;
`endif
  always #5 clk = ~clk;
  key_source_arbiter #(.HOLD_MAX(64)
`ifdef AUTO_LOCKOUT_EN
    , .LOCKOUT_CYCLES(32)
`endif
  ) u_dut (
    .clk(clk), .rst(rst), .man_code(man_code), .man_valid(man_valid), .man_release(man_release),
    .auto_code(auto_code), .auto_valid(auto_valid), .auto_release(auto_release),
    .note_code(note_code), .note_on(note_on), .note_start(note_start), .owner(owner), .drop_cnt(drop_cnt)
  );
  key_source_arbiter #(.HOLD_MAX(16)
`ifdef AUTO_LOCKOUT_EN
    , .LOCKOUT_CYCLES(32)
`endif
  ) u_hold (
    .clk(clk), .rst(rst), .man_code(man_code), .man_valid(man_valid), .man_release(man_release),
    .auto_code(auto_code), .auto_valid(auto_valid), .auto_release(auto_release),
    .note_code(h_note_code), .note_on(h_note_on), .note_start(h_note_start), .owner(h_owner),
    .drop_cnt(h_drop_cnt)
  );
  function automatic logic [11:0] st();
    return {note_on, owner, note_code, note_start};
  endfunction
  function automatic logic [11:0] h_st();
    return {h_note_on, h_owner, h_note_code, h_note_start};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press_man(input logic [7:0] c);
    man_code = c; man_valid = 1'b1; tick(1); man_valid = 1'b0;
  endtask
  task automatic rel_man(input logic [7:0] c);
    man_code = c; man_release = 1'b1; tick(1); man_release = 1'b0;
  endtask
  task automatic press_auto(input logic [7:0] c);
    auto_code = c; auto_valid = 1'b1; tick(1); auto_valid = 1'b0;
  endtask
  task automatic rel_auto(input logic [7:0] c);
    auto_code = c; auto_release = 1'b1; tick(1); auto_release = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b0; tick(2);
    exp = '0; vec++; if (st() !== exp) begin errs++; $display("FAIL reset_out: got %h want %h", st(), exp); end
    vec++; if (drop_cnt !== 8'd0) begin errs++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    rst = 1'b1; tick(1);
    vec++; if (st() !== exp) begin errs++; $display("FAIL reset_exit: got %h want %h", st(), exp); end
  endtask
  task automatic test_manual;
    press_man(8'h1A);
    exp = {1'b1, 2'b01, 8'h1A, 1'b1}; vec++; if (st() !== exp) begin errs++; $display("FAIL man_grant: got %h want %h", st(), exp); end
    tick(1);
    exp = {1'b1, 2'b01, 8'h1A, 1'b0}; vec++; if (st() !== exp) begin errs++; $display("FAIL man_hold: got %h want %h", st(), exp); end
    rel_man(8'h22);
    vec++; if (st() !== exp) begin errs++; $display("FAIL man_wrong_rel: got %h want %h", st(), exp); end
    tick(17);
    vec++; if (st() !== exp) begin errs++; $display("FAIL man_before_rel: got %h want %h", st(), exp); end
    rel_man(8'h1A);
    exp = '0; vec++; if (st() !== exp) begin errs++; $display("FAIL man_release: got %h want %h", st(), exp); end
  endtask
  task automatic test_auto_preempt;
    tick(GAP);
    press_auto(8'h21);
    exp = {1'b1, 2'b10, 8'h21, 1'b1}; vec++; if (st() !== exp) begin errs++; $display("FAIL auto_grant: got %h want %h", st(), exp); end
    tick(1);
    exp = {1'b1, 2'b10, 8'h21, 1'b0}; vec++; if (st() !== exp) begin errs++; $display("FAIL auto_hold: got %h want %h", st(), exp); end
    press_auto(8'h32);
    exp = {1'b1, 2'b10, 8'h32, 1'b1}; vec++; if (st() !== exp) begin errs++; $display("FAIL auto_retrig: got %h want %h", st(), exp); end
    tick(1);
    press_man(8'h22);
    exp = {1'b1, 2'b01, 8'h22, 1'b1}; vec++; if (st() !== exp) begin errs++; $display("FAIL preempt: got %h want %h", st(), exp); end
    tick(1);
    exp = {1'b1, 2'b01, 8'h22, 1'b0}; vec++; if (st() !== exp) begin errs++; $display("FAIL preempt_hold: got %h want %h", st(), exp); end
    rel_man(8'h22);
    exp = '0; vec++; if (st() !== exp) begin errs++; $display("FAIL preempt_rel: got %h want %h", st(), exp); end
    vec++; if (drop_cnt !== 8'd0) begin errs++; $display("FAIL preempt_drop: got %0d want 0", drop_cnt); end
  endtask
  task automatic test_simultaneous;
    tick(GAP);
    man_code = 8'h1A; auto_code = 8'h31; man_valid = 1'b1; auto_valid = 1'b1; tick(1);
    man_valid = 1'b0; auto_valid = 1'b0;
    exp = {1'b1, 2'b01, 8'h1A, 1'b1}; vec++; if (st() !== exp) begin errs++; $display("FAIL simul_grant: got %h want %h", st(), exp); end
    vec++; if (drop_cnt !== 8'd1) begin errs++; $display("FAIL simul_drop: got %0d want 1", drop_cnt); end
    rel_man(8'h1A); tick(2);
    exp = '0; vec++; if (st() !== exp) begin errs++; $display("FAIL simul_auto_cleared: got %h want %h", st(), exp); end
  endtask
  task automatic test_pending;
    tick(GAP);
    press_man(8'h2A); tick(GAP);
    press_auto(8'h3A);
    exp = {1'b1, 2'b01, 8'h2A, 1'b0}; vec++; if (st() !== exp) begin errs++; $display("FAIL pend_man_kept: got %h want %h", st(), exp); end
    press_auto(8'h31);
    vec++; if (drop_cnt !== 8'd2) begin errs++; $display("FAIL pend_overwrite_drop: got %0d want 2", drop_cnt); end
    rel_man(8'h2A);
    exp = '0; vec++; if (st() !== exp) begin errs++; $display("FAIL pend_rel: got %h want %h", st(), exp); end
    tick(1);
    exp = {1'b1, 2'b10, 8'h31, 1'b1}; vec++; if (st() !== exp) begin errs++; $display("FAIL pend_auto_grant: got %h want %h", st(), exp); end
    rel_auto(8'h31);
    exp = '0; vec++; if (st() !== exp) begin errs++; $display("FAIL pend_auto_rel: got %h want %h", st(), exp); end
  endtask
  task automatic test_non_note;
    man_code = 8'h5A; auto_code = 8'h5A; man_valid = 1'b1; auto_valid = 1'b1; tick(1);
    man_valid = 1'b0; auto_valid = 1'b0;
    exp = '0; vec++; if (st() !== exp) begin errs++; $display("FAIL nonnote_state: got %h want %h", st(), exp); end
    tick(1);
    vec++; if (drop_cnt !== 8'd2) begin errs++; $display("FAIL nonnote_drop: got %0d want 2", drop_cnt); end
  endtask
  task automatic test_hold;
    rst = 1'b0; tick(1); rst = 1'b1; tick(1);
    press_man(8'h1A);
    exp = {1'b1, 2'b01, 8'h1A, 1'b1}; vec++; if (h_st() !== exp) begin errs++; $display("FAIL hold_grant: got %h want %h", h_st(), exp); end
    tick(15);
    exp = {1'b1, 2'b01, 8'h1A, 1'b0}; vec++; if (h_st() !== exp) begin errs++; $display("FAIL hold_last_on: got %h want %h", h_st(), exp); end
    tick(1);
    exp = '0; vec++; if (h_st() !== exp) begin errs++; $display("FAIL hold_timeout: got %h want %h", h_st(), exp); end
    exp = {1'b1, 2'b01, 8'h1A, 1'b0}; vec++; if (st() !== exp) begin errs++; $display("FAIL hold_long_still_on: got %h want %h", st(), exp); end
    rel_man(8'h1A);
  endtask
  task automatic test_async_reset;
    press_man(8'h22); tick(1);
    #2 rst = 1'b0;
    #1;
    exp = '0; vec++; if (st() !== exp) begin errs++; $display("FAIL async_reset: got %h want %h", st(), exp); end
    tick(2); rst = 1'b1; tick(1);
    vec++; if (st() !== exp) begin errs++; $display("FAIL reset_exit_1: got %h want %h", st(), exp); end
    tick(1);
    vec++; if (st() !== exp) begin errs++; $display("FAIL reset_exit_2: got %h want %h", st(), exp); end
  endtask
`ifdef AUTO_LOCKOUT_EN
  task automatic test_lockout;
    press_man(8'h1A); rel_man(8'h1A); tick(8);
    press_auto(8'h21);
    exp = '0; vec++; if (st() !== exp) begin errs++; $display("FAIL lock_muted: got %h want %h", st(), exp); end
    vec++; if (drop_cnt !== 8'd1) begin errs++; $display("FAIL lock_drop: got %0d want 1", drop_cnt); end
    tick(29);
    press_auto(8'h21);
    exp = {1'b1, 2'b10, 8'h21, 1'b1}; vec++; if (st() !== exp) begin errs++; $display("FAIL lock_expired: got %h want %h", st(), exp); end
    rel_auto(8'h21);
  endtask
`endif
  initial begin
    test_reset;
    test_manual;
    test_auto_preempt;
    test_simultaneous;
    test_pending;
    test_non_note;
    test_hold;
    test_async_reset;
`ifdef AUTO_LOCKOUT_EN
    test_lockout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
